// File: rtl/i3c_target_sdr_responder.sv
// I3C SDR target responder: answers private writes/reads to STATIC_ADDR on an
// oversampled SCL/SDA pair, delivering written bytes and pulling read bytes.
module i3c_target_sdr_responder #(
   parameter logic [6:0]  STATIC_ADDR = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
      ST_WR_TBIT, ST_RD_DATA, ST_RD_TBIT, ST_WAIT_STOP
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   rnw_q, rnw_d, ack_q, ack_d, t_bit_q, t_bit_d;
   logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d, rx_parity_err_q, rx_parity_err_d;
   logic                   tx_load;
   logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   // Read source handshake: a byte moves when tx_valid and tx_ready are both
   // high in the same clk; tx_ready is a single-clk pulse, tx_data is captured then.
   assign tx_ready      = tx_load & ~rst;
   assign sda_oe        = sda_oe_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_parity_err_q;
   assign busy          = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q      <= '1;
         sda_sync_q      <= '1;
         scl_prev_q      <= 1'b1;
         sda_prev_q      <= 1'b1;
         state_q         <= ST_IDLE;
         bit_cnt_q       <= 4'd0;
         shreg_q         <= 8'h00;
         rnw_q           <= 1'b0;
         ack_q           <= 1'b0;
         t_bit_q         <= 1'b0;
         sda_oe_q        <= 1'b0;
         busy_q          <= 1'b0;
         rx_data_q       <= 8'h00;
         rx_valid_q      <= 1'b0;
         rx_parity_err_q <= 1'b0;
      end else begin
         scl_sync_q      <= scl_sync_d;
         sda_sync_q      <= sda_sync_d;
         scl_prev_q      <= scl_prev_d;
         sda_prev_q      <= sda_prev_d;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         shreg_q         <= shreg_d;
         rnw_q           <= rnw_d;
         ack_q           <= ack_d;
         t_bit_q         <= t_bit_d;
         sda_oe_q        <= sda_oe_d;
         busy_q          <= busy_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         rx_parity_err_q <= rx_parity_err_d;
      end
   end

   always_comb begin
      scl_sync_d      = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d      = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_d      = scl_s;
      sda_prev_d      = sda_s;
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shreg_d         = shreg_q;
      rnw_d           = rnw_q;
      ack_d           = ack_q;
      t_bit_d         = t_bit_q;
      sda_oe_d        = sda_oe_q;
      busy_d          = busy_q;
      rx_data_d       = rx_data_q;
      rx_valid_d      = 1'b0;
      rx_parity_err_d = 1'b0;
      tx_load         = 1'b0;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         busy_d    = 1'b1;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = ST_IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shreg_d   = {shreg_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     rnw_d = sda_s;
                     ack_d = (shreg_q[6:0] == STATIC_ADDR) && (!sda_s || tx_valid);
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d = ack_q;
                  state_d  = ack_q ? ST_ADDR_ACK : ST_WAIT_STOP;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (rnw_q) begin
                     tx_load = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) state_d = ST_WR_TBIT;
               end
            end
            ST_WR_TBIT: begin
               // Odd parity: T is the complement of the byte's XOR reduction.
               if (scl_rise) begin
                  if (sda_s == ~^shreg_q) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = shreg_q;
                  end else begin
                     rx_parity_err_d = 1'b1;
                  end
                  bit_cnt_d = 4'd0;
                  state_d   = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     t_bit_d  = tx_valid;
                     sda_oe_d = ~tx_valid;
                     state_d  = ST_RD_TBIT;
                  end else begin
                     sda_oe_d  = ~shreg_q[7];
                     shreg_d   = {shreg_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RD_TBIT: begin
               // A low SDA while T is released means the controller ended the read.
               if (scl_rise && t_bit_q && !sda_s) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_WAIT_STOP;
               end else if (scl_fall) begin
                  if (t_bit_q) begin
                     tx_load = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WAIT_STOP;
                  end
               end
            end
            ST_WAIT_STOP: sda_oe_d = 1'b0;
            default: ;
         endcase
      end

      // Bit 7 goes on the bus at the same fall that consumes the byte.
      if (tx_load) begin
         shreg_d   = {tx_data[6:0], 1'b0};
         sda_oe_d  = ~tx_data[7];
         bit_cnt_d = 4'd1;
         state_d   = ST_RD_DATA;
      end
   end

endmodule

// File: tb/tb_i3c_target_sdr_responder.sv
// Bench for i3c_target_sdr_responder: a bit-level SDR controller drives the bus,
// a behavioural model predicts port events into a queue, and a monitor checks them.
module tb_i3c_target_sdr_responder;

   localparam int         Q       = 6;
   localparam int         H       = 12;
   localparam logic [6:0] ADDR    = 7'h50;
   localparam logic [1:0] EV_RX   = 2'd0;
   localparam logic [1:0] EV_PERR = 2'd1;
   localparam logic [1:0] EV_TXR  = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       scl_i, sda_i;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_parity_err;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       busy;

   logic [9:0] exp_q[$];
   logic [7:0] tx_src_q[$];
   int         n_checks = 0;
   int         n_fail = 0;

   logic [7:0] wr_bytes[4];
   logic       wr_t[4];
   int         wr_n;
   logic [7:0] rd_bytes[4];
   int         rd_k;

   assign scl_i = scl_drv;
   assign sda_i = sda_drv & ~sda_oe;

   i3c_target_sdr_responder #(.STATIC_ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic odd_t(input logic [7:0] b);
      return ($countones(b) % 2) == 0;
   endfunction

   // driver tasks: controller side of the bus
   task automatic bus_bit(input logic b, output logic s);
      sda_drv = b;
      wait_clks(Q);
      scl_drv = 1'b1;
      wait_clks(H);
      s = sda_i;
      scl_drv = 1'b0;
      wait_clks(Q);
   endtask

   task automatic do_start();
      sda_drv = 1'b1;
      wait_clks(Q);
      scl_drv = 1'b1;
      wait_clks(H);
      sda_drv = 1'b0;
      wait_clks(H);
      scl_drv = 1'b0;
      wait_clks(Q);
      check("busy_after_start", busy, 1);
   endtask

   task automatic do_stop();
      sda_drv = 1'b0;
      wait_clks(Q);
      scl_drv = 1'b1;
      wait_clks(H);
      sda_drv = 1'b1;
      wait_clks(H);
      check("busy_after_stop", busy, 0);
   endtask

   task automatic send_addr(input logic [6:0] a, input logic rnw, output logic ack);
      logic [7:0] v;
      logic       s;
      v = {a, rnw};
      for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic write_byte(input logic [7:0] b, input logic t);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(t, s);
   endtask

   task automatic read_byte(output logic [7:0] b, output logic t);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         b[i] = s;
      end
      bus_bit(1'b1, t);
   endtask

   task automatic write_txn(input logic [6:0] a, input bit end_stop);
      logic ack, exp_a;
      exp_a = (a == ADDR);
      do_start();
      send_addr(a, 1'b0, ack);
      check("wr_addr_ack", ack, exp_a);
      for (int i = 0; i < wr_n; i++) begin
         if (exp_a) begin
            if (wr_t[i] == odd_t(wr_bytes[i])) exp_q.push_back({EV_RX, wr_bytes[i]});
            else exp_q.push_back({EV_PERR, 8'h00});
         end
         write_byte(wr_bytes[i], wr_t[i]);
      end
      if (end_stop) do_stop();
   endtask

   task automatic read_txn(input logic [6:0] a, input bit end_stop);
      logic       ack, exp_a, t;
      logic [7:0] b;
      for (int i = 0; i < rd_k; i++) tx_src_q.push_back(rd_bytes[i]);
      exp_a = (a == ADDR) && (rd_k > 0);
      if (exp_a) for (int i = 0; i < rd_k; i++) exp_q.push_back({EV_TXR, rd_bytes[i]});
      wait_clks(2);
      do_start();
      send_addr(a, 1'b1, ack);
      check("rd_addr_ack", ack, exp_a);
      if (exp_a) begin
         for (int i = 0; i < rd_k; i++) begin
            read_byte(b, t);
            check("rd_byte", b, rd_bytes[i]);
            check("rd_tbit", t, (i < rd_k - 1));
            if (!t) break;
         end
      end
      if (end_stop) do_stop();
      wait_clks(2);
      tx_src_q.delete();
   endtask

   // read-data source: pops the byte the clk after it was consumed
   initial begin : tx_source
      logic pop_pending;
      pop_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (pop_pending && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
         pop_pending = tx_ready;
         tx_valid = (tx_src_q.size() > 0);
         tx_data  = tx_valid ? tx_src_q[0] : 8'h00;
      end
   end

   // scoreboard monitor
   initial begin : monitor
      logic       prev_oe;
      logic [9:0] act;
      int         n_pulse;
      prev_oe = 1'b0;
      forever begin
         @(negedge clk);
         n_pulse = int'(rx_valid) + int'(rx_parity_err) + int'(tx_ready);
         if (n_pulse > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_overlap: %0d pulses in one clk, expected at most 1", n_pulse);
         end
         if (n_pulse > 0) begin
            act = rx_valid ? {EV_RX, rx_data} : rx_parity_err ? {EV_PERR, 8'h00} : {EV_TXR, tx_data};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got 0x%0h, expected none", act);
            end else begin
               check("event", act, exp_q.pop_front());
            end
         end
         if (sda_oe !== prev_oe) check("sda_oe_change_scl_low", scl_drv, 0);
         prev_oe = sda_oe;
      end
   end

   initial begin : stimulus
      logic       ack;
      logic [6:0] a;
      int         sel;
      bit         end_stop;

      rst = 1'b1;
      wait_clks(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_parity_err", rx_parity_err, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      wait_clks(4);

      wr_n = 2; wr_bytes[0] = 8'hA5; wr_t[0] = 1'b1; wr_bytes[1] = 8'h3C; wr_t[1] = 1'b1;
      write_txn(7'h50, 1'b1);
      wr_n = 2; wr_bytes[0] = 8'h0F; wr_t[0] = 1'b0; wr_bytes[1] = 8'h01; wr_t[1] = 1'b0;
      write_txn(7'h50, 1'b1);
      rd_k = 2; rd_bytes[0] = 8'h81; rd_bytes[1] = 8'h7E;
      read_txn(7'h50, 1'b1);
      wr_n = 1; wr_bytes[0] = 8'hA5; wr_t[0] = 1'b1;
      write_txn(7'h51, 1'b1);
      rd_k = 0;
      read_txn(7'h50, 1'b1);

      // reset while the target is pulling SDA low in a read
      tx_src_q.push_back(8'h00);
      exp_q.push_back({EV_TXR, 8'h00});
      wait_clks(2);
      do_start();
      send_addr(7'h50, 1'b1, ack);
      check("rst_rd_ack", ack, 1);
      check("sda_oe_driving", sda_oe, 1);
      rst = 1'b1;
      wait_clks(1);
      check("sda_oe_released_by_rst", sda_oe, 0);
      scl_drv = 1'b1;
      wait_clks(2);
      sda_drv = 1'b1;
      wait_clks(2);
      rst = 1'b0;
      wait_clks(3);
      check("busy_after_rst", busy, 0);
      tx_src_q.delete();
      wr_n = 1; wr_bytes[0] = 8'h3C; wr_t[0] = 1'b1;
      write_txn(7'h50, 1'b1);

      // randomized transactions, some chained by repeated START
      for (int n = 0; n < 25; n++) begin
         sel = $urandom_range(0, 4);
         a = (sel == 0) ? 7'h51 : (sel == 1) ? 7'($urandom_range(0, 127)) : ADDR;
         end_stop = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 0) begin
            wr_n = $urandom_range(1, 3);
            for (int i = 0; i < wr_n; i++) begin
               wr_bytes[i] = 8'($urandom_range(0, 255));
               wr_t[i] = ($urandom_range(0, 3) != 0) ? odd_t(wr_bytes[i]) : ~odd_t(wr_bytes[i]);
            end
            write_txn(a, end_stop);
         end else begin
            rd_k = $urandom_range(0, 3);
            for (int i = 0; i < rd_k; i++) rd_bytes[i] = 8'($urandom_range(0, 255));
            read_txn(a, end_stop);
         end
      end
      do_stop();

      wait_clks(20);
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
